// File: rtl/subcarrier_mapper.sv
// -----------------------------------------------------------------------------
// subcarrier_mapper
//   Places the modulated I/Q data stream onto one NFFT-point OFDM symbol in
//   natural subcarrier order (sc = -NFFT/2 .. NFFT/2-1, idx = sc + NFFT/2).
//   Guard bands and the DC carrier are emitted as zero, eight BPSK pilots
//   are inserted on I, and input symbols are consumed only on data slots.
//   All outputs are registered; out_ready is combinational from in_ready.
//
//   Optional feature macro: PILOT_PRBS_EN
//     defined   : pilot polarity w follows an 11-bit x^11+x^9+1 PRBS that
//                 steps once per symbol (on the idx-0 emission).
//     undefined : w = 0 for every symbol, no PRBS register.
// -----------------------------------------------------------------------------
module subcarrier_mapper #(
  parameter int                 NFFT      = 256,
  parameter int                 NGUARD_LO = 28,
  parameter int                 NGUARD_HI = 27,
  parameter logic signed [15:0] PILOT_AMP = 16'sh4000  // must not be -32768
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [15:0] in_I,
  input  logic signed [15:0] in_Q,
  input  logic               in_valid,
  output logic               out_ready,
  input  logic               in_ready,
  output logic               out_valid,
  output logic signed [15:0] I,
  output logic signed [15:0] Q,
  output logic               sym_start,
  output logic               sym_end
);

  localparam int IW   = $clog2(NFFT);
  localparam int HALF = NFFT / 2;

  // Slot boundaries in idx space.
  localparam logic [IW-1:0] IDX_LAST     = IW'(NFFT - 1);
  localparam logic [IW-1:0] IDX_GUARD_LO = IW'(NGUARD_LO);            // first non-guard idx
  localparam logic [IW-1:0] IDX_GUARD_HI = IW'(NFFT - 1 - NGUARD_HI); // last non-guard idx
  localparam logic [IW-1:0] IDX_DC       = IW'(HALF);

  // Pilot carriers: +P at sc -88,-38,63,88 ; -P at sc -63,-13,13,38.
  localparam logic [IW-1:0] P_M88 = IW'(HALF - 88);
  localparam logic [IW-1:0] P_M63 = IW'(HALF - 63);
  localparam logic [IW-1:0] P_M38 = IW'(HALF - 38);
  localparam logic [IW-1:0] P_M13 = IW'(HALF - 13);
  localparam logic [IW-1:0] P_P13 = IW'(HALF + 13);
  localparam logic [IW-1:0] P_P38 = IW'(HALF + 38);
  localparam logic [IW-1:0] P_P63 = IW'(HALF + 63);
  localparam logic [IW-1:0] P_P88 = IW'(HALF + 88);

  // FSM encoding.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // State and output registers.
  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic signed [15:0] i_q, i_d;
  logic signed [15:0] q_q, q_d;
  logic               sym_start_q, sym_start_d;
  logic               sym_end_q, sym_end_d;

  // Decode / datapath helpers.
  logic               slot_free;
  logic               is_guard;
  logic               is_dc;
  logic               is_pilot_pos;
  logic               is_pilot_neg;
  logic               is_data;
  logic               pilot_w;
  logic signed [15:0] pilot_p;
  logic signed [15:0] slot_i;
  logic               emit;
  logic signed [15:0] emit_i;
  logic signed [15:0] emit_q;
  logic               sym_begin;
  logic               out_ready_c;

  // The output register can take a new value when empty or being drained.
  assign slot_free = !out_valid_q || in_ready;

  // Classify the slot that will be emitted next.
  always_comb begin
    is_guard     = (idx_q < IDX_GUARD_LO) || (idx_q > IDX_GUARD_HI);
    is_dc        = (idx_q == IDX_DC);
    is_pilot_pos = (idx_q == P_M88) || (idx_q == P_M38) ||
                   (idx_q == P_P63) || (idx_q == P_P88);
    is_pilot_neg = (idx_q == P_M63) || (idx_q == P_M13) ||
                   (idx_q == P_P13) || (idx_q == P_P38);
    is_data      = !(is_guard || is_dc || is_pilot_pos || is_pilot_neg);
  end

`ifdef PILOT_PRBS_EN
  // Pilot polarity from an 11-bit x^11+x^9+1 PRBS. The symbol's w is latched
  // from bit 10 on the idx-0 emission, in the same cycle the PRBS steps, so
  // symbol 0 sees the seed value.
  logic [10:0] prbs_q, prbs_d;
  logic        pilot_w_q, pilot_w_d;

  // Step the PRBS and capture w at the start of each symbol.
  always_comb begin
    prbs_d    = prbs_q;
    pilot_w_d = pilot_w_q;
    if (sym_begin) begin
      pilot_w_d = prbs_q[10];
      prbs_d    = {prbs_q[9:0], prbs_q[10] ^ prbs_q[8]};
    end
  end

  // PRBS registers; the seed is restored by reset so every run is repeatable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prbs_q    <= 11'h7FF;
      pilot_w_q <= 1'b0;
    end else begin
      prbs_q    <= prbs_d;
      pilot_w_q <= pilot_w_d;
    end
  end

  assign pilot_w = pilot_w_q;
`else
  assign pilot_w = 1'b0;
`endif

  // Value of a non-data slot: zero for guard/DC, +-P on I for pilots.
  always_comb begin
    pilot_p = pilot_w ? -PILOT_AMP : PILOT_AMP;
    if (is_pilot_pos) begin
      slot_i = pilot_p;
    end else if (is_pilot_neg) begin
      slot_i = -pilot_p;
    end else begin
      slot_i = '0;
    end
  end

  // Next-state logic: decide whether a slot is emitted this cycle and what it carries.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch can be inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    q_d         = q_q;
    sym_start_d = sym_start_q;
    sym_end_d   = sym_end_q;
    emit        = 1'b0;
    emit_i      = '0;
    emit_q      = '0;
    sym_begin   = 1'b0;
    out_ready_c = 1'b0;

    if (slot_free) begin
      if (state_q == S_IDLE) begin
        // Start a symbol only when the modulator has data pending; the guard
        // at idx 0 is emitted without consuming that input.
        if (in_valid) begin
          emit      = 1'b1;
          sym_begin = 1'b1;
        end
      end else if (is_data) begin
        out_ready_c = 1'b1;
        if (in_valid) begin
          emit   = 1'b1;
          emit_i = in_I;
          emit_q = in_Q;
        end
      end else begin
        emit   = 1'b1;
        emit_i = slot_i;
      end

      if (emit) begin
        out_valid_d = 1'b1;
        i_d         = emit_i;
        q_d         = emit_q;
        sym_start_d = (idx_q == '0);
        sym_end_d   = (idx_q == IDX_LAST);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RUN;
        end
      end else begin
        // Bubble: nothing to send; I/Q keep their last value, flags clear.
        out_valid_d = 1'b0;
        sym_start_d = 1'b0;
        sym_end_d   = 1'b0;
      end
    end
  end

  // State and output registers; reset drops any partial symbol.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      sym_start_q <= 1'b0;
      sym_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      q_q         <= q_d;
      sym_start_q <= sym_start_d;
      sym_end_q   <= sym_end_d;
    end
  end

  assign out_ready = out_ready_c;
  assign out_valid = out_valid_q;
  assign I         = i_q;
  assign Q         = q_q;
  assign sym_start = sym_start_q;
  assign sym_end   = sym_end_q;

endmodule

// File: tb/tb_subcarrier_mapper.sv
// -----------------------------------------------------------------------------
// tb_subcarrier_mapper
//   Directed bench for subcarrier_mapper. Inputs carry I=k, Q=-k where k is
//   the data rank within the symbol, so every data slot's expected value is
//   its own rank. Honours PILOT_PRBS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_subcarrier_mapper;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [15:0] in_I;
  logic signed [15:0] in_Q;
  logic               in_valid;
  logic               out_ready;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] I;
  logic signed [15:0] Q;
  logic               sym_start;
  logic               sym_end;

  int n_assert = 0;
  int n_fail   = 0;

  // Tracking of the most recent run.
  int                 emit_ptr;
  int                 sym_n;
  int                 k;
  int                 out_cnt;
  logic signed [15:0] cap_i [0:255];
  logic signed [15:0] cap_q [0:255];
  logic signed [15:0] pil40 [0:15];
  logic signed [15:0] pil65 [0:15];

  always #5 clock = ~clock;

  subcarrier_mapper dut (
    .clock     (clock),
    .reset     (reset),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .I         (I),
    .Q         (Q),
    .sym_start (sym_start),
    .sym_end   (sym_end)
  );

  function automatic bit is_pilot(input int idx);
    int pl [8] = '{40, 65, 90, 115, 141, 166, 191, 216};
    for (int i = 0; i < 8; i++) if (pl[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_data(input int idx);
    return !(idx < 28 || idx > 228 || idx == 128 || is_pilot(idx));
  endfunction

  // Reference value {I,Q} of slot idx for pilot polarity w.
  function automatic logic [31:0] exp_slot(input int idx, input bit w);
    int pl [8] = '{40, 65, 90, 115, 141, 166, 191, 216};
    int rank;
    logic signed [15:0] p, ei, eq;
    p  = w ? -16'sd16384 : 16'sd16384;
    ei = '0;
    eq = '0;
    if (idx == 40 || idx == 90 || idx == 191 || idx == 216) begin
      ei = p;
    end else if (idx == 65 || idx == 115 || idx == 141 || idx == 166) begin
      ei = -p;
    end else if (is_data(idx)) begin
      rank = idx - 28;
      for (int i = 0; i < 8; i++) if (pl[i] < idx) rank--;
      if (idx > 128) rank--;
      ei = 16'(rank);
      eq = 16'(-rank);
    end
    return {ei, eq};
  endfunction

  // Pilot polarity for the n-th symbol after reset. Written as the bit
  // recurrence b[m] = b[m-11] ^ b[m-9] with eleven leading ones (the seed).
  function automatic bit pilot_w(input int n);
`ifdef PILOT_PRBS_EN
    bit b [0:63];
    for (int j = 0; j < 64; j++) b[j] = (j <= 10);
    for (int j = 11; j <= n && j < 64; j++) b[j] = b[j-11] ^ b[j-9];
    return b[n];
`else
    return (n < 0);
`endif
  endfunction

  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    in_I     = '0;
    in_Q     = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Drives n_sym symbols and checks every cycle. rnd: random in_ready;
  // bubble_idx: drop in_valid for 5 cycles when that idx is next;
  // reset_idx: assert reset when that idx is next, then run n_sym more.
  task automatic run(input int n_sym, input bit rnd, input int bubble_idx,
                     input int reset_idx);
    int cycles = 0;
    int bubble_left = 0;
    bit bubble_done = 1'b0;
    bit reset_done = 1'b0;
    bit pre_ov, pre_or, pre_ss, pre_se, sf, in_hs, out_hs;
    logic signed [15:0] pre_i, pre_q;
    logic [31:0] ev;
    emit_ptr = 0;
    sym_n    = 0;
    k        = 0;
    out_cnt  = 0;
    while (out_cnt < 256 * n_sym && cycles < 2000 * n_sym) begin
      cycles++;
      if (bubble_idx >= 0 && !bubble_done && emit_ptr == bubble_idx) begin
        bubble_left = 5;
        bubble_done = 1'b1;
      end
      if (reset_idx >= 0 && !reset_done && emit_ptr == reset_idx) begin
        reset_done = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_assert++;
        if ({out_valid, I, Q, sym_start, sym_end, out_ready} !== 36'd0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs: got ov=%b I=%0d Q=%0d ss=%b se=%b or=%b, want all 0",
                   out_valid, I, Q, sym_start, sym_end, out_ready);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        emit_ptr = 0;
        sym_n    = 0;
        k        = 0;
        out_cnt  = 0;
      end

      in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = (bubble_left == 0);
      in_I     = 16'(k);
      in_Q     = 16'(-k);
      #1;
      pre_ov = out_valid;
      pre_i  = I;
      pre_q  = Q;
      pre_ss = sym_start;
      pre_se = sym_end;
      pre_or = out_ready;
      sf     = !pre_ov || in_ready;
      n_assert++;
      if (pre_or !== (sf && is_data(emit_ptr))) begin
        n_fail++;
        $display("FAIL out_ready: next idx=%0d got %b want %b", emit_ptr, pre_or,
                 sf && is_data(emit_ptr));
      end
      in_hs  = in_valid && pre_or;
      out_hs = pre_ov && in_ready;

      @(posedge clock);
      #1;
      if (in_hs) k++;
      if (out_hs) out_cnt++;

      if (bubble_left > 0) begin
        bubble_left--;
        n_assert++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL bubble_out_valid: got %b want 0", out_valid);
        end
      end

      if (sf && out_valid === 1'b1) begin
        ev = exp_slot(emit_ptr, pilot_w(sym_n));
        n_assert++;
        if ({I, Q, sym_start, sym_end} !== {ev, emit_ptr == 0, emit_ptr == 255}) begin
          n_fail++;
          $display("FAIL emit idx=%0d sym=%0d: got I=%0d Q=%0d ss=%b se=%b, want I=%0d Q=%0d ss=%b se=%b",
                   emit_ptr, sym_n, I, Q, sym_start, sym_end, $signed(ev[31:16]),
                   $signed(ev[15:0]), emit_ptr == 0, emit_ptr == 255);
        end
        if (sym_n == 0) begin
          cap_i[emit_ptr] = I;
          cap_q[emit_ptr] = Q;
        end
        if (sym_n < 16 && emit_ptr == 40) pil40[sym_n] = I;
        if (sym_n < 16 && emit_ptr == 65) pil65[sym_n] = I;
        if (emit_ptr == 255) begin
          n_assert++;
          if (k !== 192) begin
            n_fail++;
            $display("FAIL inputs_per_symbol sym=%0d: got %0d want 192", sym_n, k);
          end
          k        = 0;
          emit_ptr = 0;
          sym_n++;
        end else begin
          emit_ptr++;
        end
      end else if (!sf) begin
        n_assert++;
        if ({out_valid, I, Q, sym_start, sym_end} !== {pre_ov, pre_i, pre_q, pre_ss, pre_se}) begin
          n_fail++;
          $display("FAIL hold_stable: got ov=%b I=%0d Q=%0d, want ov=%b I=%0d Q=%0d",
                   out_valid, I, Q, pre_ov, pre_i, pre_q);
        end
      end
    end
    n_assert++;
    if (out_cnt != 256 * n_sym) begin
      n_fail++;
      $display("FAIL run_complete: got %0d outputs want %0d within %0d cycles",
               out_cnt, 256 * n_sym, cycles);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_ready = 1'b1;
    in_I     = 16'sd5;
    in_Q     = 16'sd7;
    repeat (3) @(posedge clock);
    #1;
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_assert++;
    if (I !== 16'sd0) begin n_fail++; $display("FAIL reset_I: got %0d want 0", I); end
    n_assert++;
    if (Q !== 16'sd0) begin n_fail++; $display("FAIL reset_Q: got %0d want 0", Q); end
    n_assert++;
    if (sym_start !== 1'b0) begin n_fail++; $display("FAIL reset_sym_start: got %b want 0", sym_start); end
    n_assert++;
    if (sym_end !== 1'b0) begin n_fail++; $display("FAIL reset_sym_end: got %b want 0", sym_end); end
    n_assert++;
    if (out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready: got %b want 0", out_ready); end
    reset = 1'b0;
  endtask

  task automatic test_full_symbol();
    apply_reset();
    run(1, 1'b0, -1, -1);
    n_assert++;
    if ({cap_i[0], cap_q[0]} !== 32'd0) begin n_fail++; $display("FAIL idx0: got (%0d,%0d) want (0,0)", cap_i[0], cap_q[0]); end
    n_assert++;
    if ({cap_i[28], cap_q[28]} !== 32'd0) begin n_fail++; $display("FAIL idx28: got (%0d,%0d) want (0,0)", cap_i[28], cap_q[28]); end
    n_assert++;
    if (cap_i[41] !== 16'sd12 || cap_q[41] !== -16'sd12) begin
      n_fail++; $display("FAIL idx41: got (%0d,%0d) want (12,-12)", cap_i[41], cap_q[41]);
    end
    n_assert++;
    if ({cap_i[128], cap_q[128]} !== 32'd0) begin n_fail++; $display("FAIL idx128_dc: got (%0d,%0d) want (0,0)", cap_i[128], cap_q[128]); end
    n_assert++;
    if (cap_i[228] !== 16'sd191 || cap_q[228] !== -16'sd191) begin
      n_fail++; $display("FAIL idx228: got (%0d,%0d) want (191,-191)", cap_i[228], cap_q[228]);
    end
    n_assert++;
    if ({cap_i[229], cap_q[229], cap_i[255], cap_q[255]} !== 64'd0) begin
      n_fail++; $display("FAIL guard_hi: got (%0d,%0d) (%0d,%0d) want zeros", cap_i[229], cap_q[229], cap_i[255], cap_q[255]);
    end
  endtask

  task automatic test_pilots();
`ifdef PILOT_PRBS_EN
    int n = 12;
`else
    int n = 3;
`endif
    apply_reset();
    run(n, 1'b0, -1, -1);
`ifdef PILOT_PRBS_EN
    n_assert++;
    if (pil40[0] !== -16'sd16384) begin n_fail++; $display("FAIL prbs_sym0_idx40: got %0d want -16384", pil40[0]); end
    for (int s = 0; s < n; s++) begin
      n_assert++;
      if (pil40[s] !== (pilot_w(s) ? -16'sd16384 : 16'sd16384)) begin
        n_fail++; $display("FAIL prbs_idx40 sym=%0d: got %0d want %0d", s, pil40[s], pilot_w(s) ? -16384 : 16384);
      end
    end
`else
    for (int s = 0; s < n; s++) begin
      n_assert++;
      if (pil40[s] !== 16'sd16384) begin n_fail++; $display("FAIL pilot_idx40 sym=%0d: got %0d want 16384", s, pil40[s]); end
      n_assert++;
      if (pil65[s] !== -16'sd16384) begin n_fail++; $display("FAIL pilot_idx65 sym=%0d: got %0d want -16384", s, pil65[s]); end
    end
`endif
  endtask

  task automatic test_stall();
    apply_reset();
    run(2, 1'b1, -1, -1);
  endtask

  task automatic test_bubble();
    apply_reset();
    run(1, 1'b0, 60, -1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    run(1, 1'b0, -1, 150);
  endtask

  initial begin
    test_reset();
    test_full_symbol();
    test_pilots();
    test_stall();
    test_bubble();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
